// File: rtl/nn_pkg.sv
// Shared neural-network datapath package: default activation-stage
// constants and the ReLU/shift/saturate quantiser used by the activation
// output stages.
package nn_pkg;

   // Default activation-stage configuration.
   localparam int NN_WIDTH = 8;
   localparam int NN_SHIFT = 4;
   localparam int NN_DEPTH = 2;
   localparam int NN_CNT_W = 16;

   // The quantiser works on fixed wide operands so a single function can
   // serve stages of any width up to these limits. Callers sign-extend the
   // accumulation into QUANT_IN_W bits and keep the low bits of the result.
   localparam int QUANT_IN_W  = 64;
   localparam int QUANT_OUT_W = 32;

   localparam logic signed [QUANT_IN_W:0] QUANT_ONE = (QUANT_IN_W + 1)'(1);

   // Quantiser result: activation value and saturation flag.
   typedef struct packed {
      logic [QUANT_OUT_W-1:0] value;
      logic                   sat;
   } quant_t;

   // ReLU, then arithmetic right shift (optionally round-half-up), then
   // saturate to an unsigned 'width'-bit value. The extra headroom bit keeps
   // the rounding add from overflowing at the most positive input.
   function automatic quant_t relu_quant(
      input logic signed [QUANT_IN_W-1:0] acc,
      input int unsigned                  shift,
      input int unsigned                  width,
      input logic                         round_en
   );
      logic signed [QUANT_IN_W:0] wide;
      logic signed [QUANT_IN_W:0] t;
      logic signed [QUANT_IN_W:0] max_v;
      quant_t                     q;
      q     = '0;
      wide  = {acc[QUANT_IN_W-1], acc};
      t     = '0;
      max_v = (QUANT_ONE <<< width) - QUANT_ONE;
      // Non-positive sums clamp to zero; only strictly positive sums scale.
      if (!acc[QUANT_IN_W-1] && (acc != '0)) begin
         if (round_en && (shift != 0)) begin
            wide = wide + (QUANT_ONE <<< (shift - 1));
         end
         t = wide >>> shift;
         if (t > max_v) begin
            q.value = max_v[QUANT_OUT_W-1:0];
            q.sat   = 1'b1;
         end else begin
            q.value = t[QUANT_OUT_W-1:0];
         end
      end
      return q;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head. Pointers wrap modulo DEPTH
// (a power of two); occupancy is tracked in a separate 0..DEPTH counter so
// full and empty never alias. Push and pop in the same cycle are legal even
// when full. The read port shows zero while the FIFO is empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_B = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_B-1:0] cnt_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_B'(DEPTH));
   assign count   = cnt_q;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CNT_B'(1);
            2'b01:   cnt_q <= cnt_q - CNT_B'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage array write.
   // NOTE: the array is deliberately not reset; stale entries are never
   // visible because the read port is gated by the reset occupancy counter.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/relu_out_stage.sv
// ReLU output stage: takes each final signed 2*WIDTH-bit accumulation,
// applies ReLU, right-shifts by SHIFT and saturates to an unsigned
// WIDTH-bit activation. One register stage (S1) feeds a small output FIFO
// behind a valid/ready handshake. Saturated results are counted.
// Build option: define RELU_OUT_ROUND_EN for round-half-up instead of
// truncation on the shift of positive sums.
module relu_out_stage
   import nn_pkg::*;
#(
   parameter int WIDTH = NN_WIDTH,
   parameter int SHIFT = NN_SHIFT,
   parameter int DEPTH = NN_DEPTH,
   parameter int CNT_W = NN_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*WIDTH-1:0]   in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [CNT_W-1:0]     sat_cnt,
   output logic                 busy
);

`ifdef RELU_OUT_ROUND_EN
   localparam logic ROUND_EN = 1'b1;
`else
   localparam logic ROUND_EN = 1'b0;
`endif

   localparam int CNT_B = $clog2(DEPTH + 1);

   logic                         accept;
   logic                         pop;
   logic signed [QUANT_IN_W-1:0] in_ext;
   quant_t                       quant;
   logic                         s1_valid;
   logic [WIDTH-1:0]             s1_data;
   logic [CNT_B-1:0]             fifo_count;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic                         unused_quant;

   // Sign-extend the accumulation into the quantiser's operand width.
   assign in_ext = {{(QUANT_IN_W - 2*WIDTH){in_data[2*WIDTH-1]}}, in_data};

   // Combinational quantiser on the incoming accumulation.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      quant = '0;
      quant = relu_quant(in_ext, SHIFT, WIDTH, ROUND_EN);
   end

   // The value never exceeds 2^WIDTH-1, so the upper bits carry nothing.
   assign unused_quant = ^{quant.value[QUANT_OUT_W-1:WIDTH], fifo_full};

   // Head pops on the output handshake.
   assign pop = out_valid & out_ready;

   // Space exists when FIFO contents plus the S1 entry leave a slot free,
   // or a slot frees up this cycle. Independent of in_valid by design.
   assign in_ready = ((int'(fifo_count) + int'(s1_valid)) < DEPTH) || pop;
   assign accept   = in_valid & in_ready;

   // S1 register: capture the quantised result on every accepted input.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) s1_data <= quant.value[WIDTH-1:0];
      end
   end

   // Saturation event counter: counts S1 captures that clipped, sticks at
   // all ones instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat_cnt <= '0;
      end else if (accept && quant.sat && (sat_cnt != '1)) begin
         sat_cnt <= sat_cnt + CNT_W'(1);
      end
   end

   // Output buffer behind S1; S1 always finds room thanks to in_ready.
   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (s1_valid),
      .pop     (pop),
      .wr_data (s1_data),
      .rd_data (out_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign out_valid = ~fifo_empty;
   assign busy      = s1_valid | ~fifo_empty;

endmodule

// File: tb/tb_relu_out_stage.sv
// Self-checking bench for relu_out_stage (WIDTH=8, SHIFT=4, DEPTH=2).
// Expected activations come from an integer-arithmetic model of the
// ReLU/shift/saturate rule; a queue scoreboard checks order and content.
module tb_relu_out_stage;

   localparam int WIDTH = 8;
   localparam int SHIFT = 4;
   localparam int DEPTH = 2;
   localparam int CNT_W = 16;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [2*WIDTH-1:0] in_data;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [CNT_W-1:0]   sat_cnt;
   logic               busy;

   relu_out_stage #(
      .WIDTH (WIDTH),
      .SHIFT (SHIFT),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sat_cnt   (sat_cnt),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [2*WIDTH-1:0] stim_q [$];
   logic [WIDTH-1:0]   exp_q  [$];
   logic [WIDTH-1:0]   got_q  [$];
   int                 exp_sat = 0;

   // Values sampled at the falling edge by step().
   logic             s_accept, s_pop, s_valid, s_in_ready, s_busy;
   logic [WIDTH-1:0] s_out;
   logic [CNT_W-1:0] s_sat;

`ifdef RELU_OUT_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   // Reference: ReLU, divide by 2^SHIFT (optionally round half up), clip.
   function automatic logic [WIDTH-1:0] ref_act(input logic [2*WIDTH-1:0] d, output bit sat);
      int v;
      int lim;
      logic [31:0] r;
      lim = (1 << WIDTH) - 1;
      v   = int'($signed(d));
      sat = 1'b0;
      if (v <= 0) return '0;
      if (ROUND && SHIFT > 0) v = v + (1 << (SHIFT - 1));
      v = v / (1 << SHIFT);
      if (v > lim) begin
         sat = 1'b1;
         return '1;
      end
      r = v;
      return r[WIDTH-1:0];
   endfunction

   // Drive one cycle of inputs just after the rising edge, sample at the
   // falling edge and feed the scoreboard queues.
   task automatic step(input logic v, input logic [2*WIDTH-1:0] d, input logic r);
      logic [WIDTH-1:0] e;
      bit               sat;
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      @(negedge clk);
      s_accept   = in_valid & in_ready;
      s_pop      = out_valid & out_ready;
      s_valid    = out_valid;
      s_in_ready = in_ready;
      s_busy     = busy;
      s_out      = out_data;
      s_sat      = sat_cnt;
      if (s_accept) begin
         e = ref_act(in_data, sat);
         exp_q.push_back(e);
         if (sat && exp_sat < (1 << CNT_W) - 1) exp_sat++;
      end
      if (s_pop) got_q.push_back(out_data);
   endtask

   // Feed stim_q with out_ready held high until everything has drained.
   task automatic pump(input int max_cycles, output bit timed_out);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      timed_out = 1'b0;
      while (!done && !timed_out) begin
         if (stim_q.size() > 0) step(1'b1, stim_q[0], 1'b1);
         else                   step(1'b0, '0, 1'b1);
         if (s_accept) void'(stim_q.pop_front());
         done = (stim_q.size() == 0) && !s_busy && !s_accept;
         n++;
         if (n >= max_cycles) timed_out = !done;
      end
   endtask

   task automatic clear_queues();
      stim_q.delete();
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #12;
      tests_run++;
      if ({out_valid, busy, out_data, sat_cnt} !== '0) begin
         tests_failed++;
         $display("FAIL reset_hold: valid=%0b busy=%0b data=%0h sat=%0d expected all 0", out_valid, busy, out_data, sat_cnt);
      end
      #11 rst = 1'b1;
      step(1'b0, '0, 1'b0);
      tests_run++;
      if (s_in_ready !== 1'b1 || s_valid !== 1'b0 || s_out !== '0 || s_sat !== '0 || s_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release: in_ready=%0b valid=%0b data=%0h sat=%0d busy=%0b expected 1/0/0/0/0", s_in_ready, s_valid, s_out, s_sat, s_busy);
      end
   endtask

   task automatic test_basic();
      clear_queues();
      step(1'b1, 16'h0123, 1'b1);
      tests_run++;
      if (s_accept !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_accept: got %0b expected 1", s_accept);
      end
      step(1'b0, '0, 1'b1);
      tests_run++;
      if (s_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_latency_early: out_valid=%0b expected 0 one edge after accept", s_valid);
      end
      step(1'b0, '0, 1'b1);
      tests_run++;
      if (s_valid !== 1'b1 || s_out !== 8'h12) begin
         tests_failed++;
         $display("FAIL basic_result: valid=%0b data=%0h expected 1/12", s_valid, s_out);
      end
      step(1'b0, '0, 1'b1);
      tests_run++;
      if (s_valid !== 1'b0 || s_sat !== '0) begin
         tests_failed++;
         $display("FAIL basic_drain: valid=%0b sat=%0d expected 0/0", s_valid, s_sat);
      end
   endtask

   task automatic test_rounding();
      bit to;
      logic [WIDTH-1:0] e0;
      clear_queues();
      e0 = ROUND ? 8'h13 : 8'h12;
      stim_q.push_back(16'h0128);
      stim_q.push_back(16'h0127);
      pump(50, to);
      tests_run++;
      if (to || got_q.size() != 2) begin
         tests_failed++;
         $display("FAIL round_count: timeout=%0b outputs=%0d expected 0/2", to, got_q.size());
      end else if (got_q[0] !== e0 || got_q[1] !== 8'h12) begin
         tests_failed++;
         $display("FAIL round_values: got %0h,%0h expected %0h,12", got_q[0], got_q[1], e0);
      end
   endtask

   task automatic test_relu_zero();
      bit to;
      clear_queues();
      stim_q.push_back(16'hFF00);
      stim_q.push_back(16'h0000);
      pump(50, to);
      tests_run++;
      if (to || got_q.size() != 2) begin
         tests_failed++;
         $display("FAIL relu_count: timeout=%0b outputs=%0d expected 0/2", to, got_q.size());
      end else if (got_q[0] !== 8'h00 || got_q[1] !== 8'h00) begin
         tests_failed++;
         $display("FAIL relu_values: got %0h,%0h expected 0,0", got_q[0], got_q[1]);
      end
      tests_run++;
      if (s_sat !== '0) begin
         tests_failed++;
         $display("FAIL relu_sat_cnt: got %0d expected 0", s_sat);
      end
   endtask

   task automatic test_saturation();
      bit to;
      clear_queues();
      stim_q.push_back(16'h7FFF);
      stim_q.push_back(16'h0100);
      pump(50, to);
      tests_run++;
      if (to || got_q.size() != 2) begin
         tests_failed++;
         $display("FAIL sat_count: timeout=%0b outputs=%0d expected 0/2", to, got_q.size());
      end else if (got_q[0] !== 8'hFF || got_q[1] !== 8'h10) begin
         tests_failed++;
         $display("FAIL sat_values: got %0h,%0h expected ff,10", got_q[0], got_q[1]);
      end
      tests_run++;
      if (s_sat !== 16'd1) begin
         tests_failed++;
         $display("FAIL sat_cnt: got %0d expected 1", s_sat);
      end
   endtask

   task automatic test_backpressure();
      bit to;
      clear_queues();
      step(1'b1, 16'h0010, 1'b0);
      step(1'b1, 16'h0020, 1'b0);
      tests_run++;
      if (s_accept !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_second_accept: got %0b expected 1", s_accept);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 16'h0030, 1'b0);
         tests_run++;
         if (s_in_ready !== 1'b0 || s_valid !== 1'b1 || s_out !== 8'h01) begin
            tests_failed++;
            $display("FAIL bp_stall[%0d]: in_ready=%0b valid=%0b data=%0h expected 0/1/01", i, s_in_ready, s_valid, s_out);
         end
      end
      stim_q.push_back(16'h0030);
      pump(50, to);
      tests_run++;
      if (to || got_q.size() != 3) begin
         tests_failed++;
         $display("FAIL bp_count: timeout=%0b outputs=%0d expected 0/3", to, got_q.size());
      end else if (got_q[0] !== 8'h01 || got_q[1] !== 8'h02 || got_q[2] !== 8'h03) begin
         tests_failed++;
         $display("FAIL bp_order: got %0h,%0h,%0h expected 01,02,03", got_q[0], got_q[1], got_q[2]);
      end
   endtask

   task automatic test_async_reset();
      bit to;
      clear_queues();
      step(1'b1, 16'h7FFF, 1'b0);
      step(1'b1, 16'h0020, 1'b0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      #1;
      tests_run++;
      if (busy !== 1'b1 || out_valid !== 1'b1 || sat_cnt !== CNT_W'(exp_sat)) begin
         tests_failed++;
         $display("FAIL arst_before: busy=%0b valid=%0b sat=%0d expected 1/1/%0d", busy, out_valid, sat_cnt, exp_sat);
      end
      #1 rst = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || sat_cnt !== '0 || out_data !== '0) begin
         tests_failed++;
         $display("FAIL arst_immediate: valid=%0b busy=%0b sat=%0d data=%0h expected 0/0/0/0", out_valid, busy, sat_cnt, out_data);
      end
      #2 rst = 1'b1;
      clear_queues();
      exp_sat = 0;
      stim_q.push_back(16'h0050);
      pump(50, to);
      tests_run++;
      if (to || got_q.size() != 1 || got_q[0] !== 8'h05) begin
         tests_failed++;
         $display("FAIL arst_fresh: timeout=%0b outputs=%0d first=%0h expected 0/1/05", to, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
      end
   endtask

   function automatic logic [2*WIDTH-1:0] rand_data();
      logic [2*WIDTH-1:0] d;
      d = 16'($urandom());
      case ($urandom_range(0, 3))
         0: d = 16'($urandom());
         1: d = 16'($urandom_range(0, 16'h0FFF));
         2: d = 16'($urandom_range(16'h0FE0, 16'h1020));
         default: d = 16'h8000 | 16'($urandom());
      endcase
      return d;
   endfunction

   task automatic test_random();
      localparam int N = 300;
      int               sent;
      int               cycles;
      logic             vld;
      logic             rdy;
      logic [2*WIDTH-1:0] d;
      logic             prev_stall;
      logic [WIDTH-1:0] prev_out;
      logic [WIDTH-1:0] e;
      clear_queues();
      sent = 0; cycles = 0; vld = 1'b0; d = '0; prev_stall = 1'b0; prev_out = '0;
      while ((sent < N || exp_q.size() > 0) && cycles < 5000) begin
         if (!vld && sent < N && $urandom_range(0, 3) != 0) begin
            vld = 1'b1;
            d   = rand_data();
         end
         rdy = ($urandom_range(0, 3) != 0) || (sent >= N);
         step(vld, d, rdy);
         cycles++;
         if (prev_stall) begin
            tests_run++;
            if (s_valid !== 1'b1 || s_out !== prev_out) begin
               tests_failed++;
               $display("FAIL rand_stable: valid=%0b data=%0h expected 1/%0h", s_valid, s_out, prev_out);
            end
         end
         prev_stall = s_valid & ~s_pop;
         prev_out   = s_out;
         if (s_accept) begin
            vld = 1'b0;
            sent++;
         end
         while (got_q.size() > 0) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL rand_extra: unexpected output %0h", got_q[0]);
               void'(got_q.pop_front());
            end else begin
               e = exp_q.pop_front();
               if (got_q[0] !== e) begin
                  tests_failed++;
                  $display("FAIL rand_data: got %0h expected %0h", got_q[0], e);
               end
               void'(got_q.pop_front());
            end
         end
      end
      tests_run++;
      if (sent != N || exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL rand_complete: sent=%0d pending=%0d expected %0d/0", sent, exp_q.size(), N);
      end
      step(1'b0, '0, 1'b1);
      tests_run++;
      if (s_sat !== CNT_W'(exp_sat) || s_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL rand_sat_cnt: sat=%0d busy=%0b expected %0d/0", s_sat, s_busy, exp_sat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_relu_zero();
      test_saturation();
      test_backpressure();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
